// File: rtl/sram_arb_pkg.sv
// Shared types, constants and helpers for the two-port SRAM arbiter.
package sram_arb_pkg;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READ     = 2'd1,
        RMW_READ = 2'd2,
        WRITE    = 2'd3
    } state_t;

    // Port-select encoding used by the arbiter and the sequencer.
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // Byte-enable patterns that select the access flavour.
    localparam logic [3:0] BE_FULL = 4'b1111;
    localparam logic [3:0] BE_NONE = 4'b0000;

    // Build the word written back by a read-modify-write: enabled lanes come
    // from the requester, the others keep what the SRAM already holds.
    function automatic logic [31:0] merge_bytes(
        input logic [3:0]  be,
        input logic [31:0] wdata,
        input logic [31:0] rdata
    );
        logic [31:0] merged;
        merged = rdata;
        for (int n = 0; n < 4; n++) begin
            if (be[n]) begin
                merged[8*n +: 8] = wdata[8*n +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_rr_arbiter.sv
// Two-way round-robin grant for the SRAM sequencer. A request is only valid
// when its port did not see ready on the previous edge, which hides the
// requester's one-cycle delay in dropping rd/wr after completion.
module sram_rr_arbiter
    import sram_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic a_req,
    input  logic b_req,
    input  logic a_ready,
    input  logic b_ready,
    output logic grant_valid,
    output logic grant_port
);

    logic last_grant;
    logic a_valid;
    logic b_valid;

    // Qualify requests and pick a winner; on a tie the port not served last wins.
    always_comb begin
        a_valid     = a_req && !a_ready;
        b_valid     = b_req && !b_ready;
        grant_valid = enable && (a_valid || b_valid);
        if (a_valid && b_valid) begin
            grant_port = (last_grant == PORT_A) ? PORT_B : PORT_A;
        end else if (a_valid) begin
            grant_port = PORT_A;
        end else begin
            grant_port = PORT_B;
        end
    end

    // Remember the most recent grant; reset favours port A on the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= PORT_B;
        end else if (grant_valid) begin
            last_grant <= grant_port;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter and strobe sequencer for an external 512K x 32 async SRAM.
// Reads and full writes take LATENCY+1 cycles of strobe activity; partial
// writes become a read phase followed by a write phase with cs held low.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned LATENCY = 1,
    parameter int unsigned ADDR_W  = 19
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              a_rd,
    input  logic              a_wr,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [3:0]        a_be,
    input  logic [31:0]       a_wdata,
    output logic [31:0]       a_rdata,
    output logic              a_ready,

    input  logic              b_rd,
    input  logic              b_wr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [3:0]        b_be,
    input  logic [31:0]       b_wdata,
    output logic [31:0]       b_rdata,
    output logic              b_ready,

    output logic              ram_cs_b,
    output logic              ram_oe_b,
    output logic              ram_wr_b,
    output logic              ram_ub_b,
    output logic              ram_lb_b,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_dq_out,
    output logic              ram_dq_oe,
    input  logic [31:0]       ram_dq_in
);

    localparam logic [2:0] LAT = 3'(LATENCY);

    // Registered state
    state_t      state;
    logic [2:0]  lcount;
    logic        port_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;

    // Next-state values
    state_t      state_d;
    logic [2:0]  lcount_d;
    logic        port_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [ADDR_W-1:0] ram_addr_d;
    logic        cs_d;
    logic        oe_d;
    logic        wr_d;
    logic        bsel_d;
    logic [31:0] dq_out_d;
    logic        dq_oe_d;
    logic [31:0] a_rdata_d;
    logic [31:0] b_rdata_d;
    logic        a_ready_d;
    logic        b_ready_d;

    // Arbiter interface and the granted port's request fields
    logic              grant_valid;
    logic              grant_port;
    logic              g_rd;
    logic [ADDR_W-1:0] g_addr;
    logic [3:0]        g_be;
    logic [31:0]       g_wdata;

    sram_rr_arbiter u_arb (
        .clk         (clk),
        .rst         (rst),
        .enable      (state == IDLE),
        .a_req       (a_rd || a_wr),
        .b_req       (b_rd || b_wr),
        .a_ready     (a_ready),
        .b_ready     (b_ready),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    // Route the granted port's request onto a common set of signals.
    always_comb begin
        if (grant_port == PORT_A) begin
            g_rd    = a_rd;
            g_addr  = a_addr;
            g_be    = a_be;
            g_wdata = a_wdata;
        end else begin
            g_rd    = b_rd;
            g_addr  = b_addr;
            g_be    = b_be;
            g_wdata = b_wdata;
        end
    end

    // Sequencer next-state and next-output logic.
    always_comb begin
        // NOTE: every next value starts from a hold/default here so no branch
        // leaves one unassigned, which would otherwise infer a latch.
        state_d    = state;
        lcount_d   = lcount;
        port_d     = port_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        ram_addr_d = ram_addr;
        cs_d       = ram_cs_b;
        oe_d       = ram_oe_b;
        wr_d       = ram_wr_b;
        bsel_d     = ram_ub_b;
        dq_out_d   = ram_dq_out;
        dq_oe_d    = ram_dq_oe;
        a_rdata_d  = a_rdata;
        b_rdata_d  = b_rdata;
        a_ready_d  = 1'b0;
        b_ready_d  = 1'b0;

        unique case (state)
            IDLE: begin
                if (grant_valid) begin
                    port_d     = grant_port;
                    ram_addr_d = g_addr;
                    be_d       = g_be;
                    wdata_d    = g_wdata;
                    lcount_d   = LAT;
                    if (g_rd) begin
                        cs_d    = 1'b0;
                        oe_d    = 1'b0;
                        wr_d    = 1'b1;
                        bsel_d  = 1'b0;
                        state_d = READ;
                    end else if (g_be == BE_NONE) begin
                        // Nothing to write: acknowledge without touching the SRAM.
                        a_ready_d = (grant_port == PORT_A);
                        b_ready_d = (grant_port == PORT_B);
                    end else if (g_be == BE_FULL) begin
                        cs_d     = 1'b0;
                        oe_d     = 1'b1;
                        wr_d     = 1'b0;
                        bsel_d   = 1'b0;
                        dq_oe_d  = 1'b1;
                        dq_out_d = g_wdata;
                        state_d  = WRITE;
                    end else begin
                        cs_d    = 1'b0;
                        oe_d    = 1'b0;
                        wr_d    = 1'b1;
                        bsel_d  = 1'b0;
                        state_d = RMW_READ;
                    end
                end
            end

            READ: begin
                if (lcount != 3'd0) begin
                    lcount_d = lcount - 3'd1;
                end else begin
                    if (port_q == PORT_A) begin
                        a_rdata_d = ram_dq_in;
                    end else begin
                        b_rdata_d = ram_dq_in;
                    end
                    a_ready_d = (port_q == PORT_A);
                    b_ready_d = (port_q == PORT_B);
                    cs_d      = 1'b1;
                    oe_d      = 1'b1;
                    wr_d      = 1'b1;
                    bsel_d    = 1'b1;
                    state_d   = IDLE;
                end
            end

            RMW_READ: begin
                if (lcount != 3'd0) begin
                    lcount_d = lcount - 3'd1;
                end else begin
                    // Turn the bus around in one edge: oe releases as dq_oe
                    // asserts, both registered, so they never overlap.
                    oe_d     = 1'b1;
                    wr_d     = 1'b0;
                    dq_oe_d  = 1'b1;
                    dq_out_d = merge_bytes(be_q, wdata_q, ram_dq_in);
                    lcount_d = LAT;
                    state_d  = WRITE;
                end
            end

            WRITE: begin
                if (lcount != 3'd0) begin
                    lcount_d = lcount - 3'd1;
                end else begin
                    a_ready_d = (port_q == PORT_A);
                    b_ready_d = (port_q == PORT_B);
                    cs_d      = 1'b1;
                    oe_d      = 1'b1;
                    wr_d      = 1'b1;
                    bsel_d    = 1'b1;
                    dq_oe_d   = 1'b0;
                    state_d   = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples
        // the pre-edge values, independent of statement order.
        if (rst) begin
            state      <= IDLE;
            lcount     <= 3'd0;
            port_q     <= PORT_A;
            be_q       <= 4'd0;
            wdata_q    <= 32'd0;
            ram_addr   <= '0;
            ram_cs_b   <= 1'b1;
            ram_oe_b   <= 1'b1;
            ram_wr_b   <= 1'b1;
            ram_ub_b   <= 1'b1;
            ram_lb_b   <= 1'b1;
            ram_dq_out <= 32'd0;
            ram_dq_oe  <= 1'b0;
            a_rdata    <= 32'd0;
            b_rdata    <= 32'd0;
            a_ready    <= 1'b0;
            b_ready    <= 1'b0;
        end else begin
            state      <= state_d;
            lcount     <= lcount_d;
            port_q     <= port_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            ram_addr   <= ram_addr_d;
            ram_cs_b   <= cs_d;
            ram_oe_b   <= oe_d;
            ram_wr_b   <= wr_d;
            ram_ub_b   <= bsel_d;
            ram_lb_b   <= bsel_d;
            ram_dq_out <= dq_out_d;
            ram_dq_oe  <= dq_oe_d;
            a_rdata    <= a_rdata_d;
            b_rdata    <= b_rdata_d;
            a_ready    <= a_ready_d;
            b_ready    <= b_ready_d;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with LATENCY=1 and a behavioural SRAM.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_rd, a_wr, b_rd, b_wr;
    logic [18:0] a_addr, b_addr;
    logic [3:0]  a_be, b_be;
    logic [31:0] a_wdata, b_wdata;
    logic [31:0] a_rdata, b_rdata;
    logic        a_ready, b_ready;
    logic        ram_cs_b, ram_oe_b, ram_wr_b, ram_ub_b, ram_lb_b;
    logic [18:0] ram_addr;
    logic [31:0] ram_dq_out, ram_dq_in;
    logic        ram_dq_oe;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor counters (cycles with a strobe active, ready pulses)
    int cs_cnt, oe_cnt, wr_cnt, dqoe_cnt, a_rdy_cnt, b_rdy_cnt;
    int bus_viol = 0;

    logic [31:0] mem [0:(1<<19)-1];

    always #5 clk = ~clk;

    sram_arbiter #(.LATENCY(1), .ADDR_W(19)) dut (
        .clk        (clk),
        .rst        (rst),
        .a_rd       (a_rd),
        .a_wr       (a_wr),
        .a_addr     (a_addr),
        .a_be       (a_be),
        .a_wdata    (a_wdata),
        .a_rdata    (a_rdata),
        .a_ready    (a_ready),
        .b_rd       (b_rd),
        .b_wr       (b_wr),
        .b_addr     (b_addr),
        .b_be       (b_be),
        .b_wdata    (b_wdata),
        .b_rdata    (b_rdata),
        .b_ready    (b_ready),
        .ram_cs_b   (ram_cs_b),
        .ram_oe_b   (ram_oe_b),
        .ram_wr_b   (ram_wr_b),
        .ram_ub_b   (ram_ub_b),
        .ram_lb_b   (ram_lb_b),
        .ram_addr   (ram_addr),
        .ram_dq_out (ram_dq_out),
        .ram_dq_oe  (ram_dq_oe),
        .ram_dq_in  (ram_dq_in)
    );

    // Asynchronous SRAM model: drives data while selected and output-enabled.
    assign ram_dq_in = (!ram_cs_b && !ram_oe_b) ? mem[ram_addr] : 32'h0;

    // Commit a write at each edge the write strobe is held low.
    always @(posedge clk) begin
        if (!ram_cs_b && !ram_wr_b && ram_dq_oe) mem[ram_addr] = ram_dq_out;
    end

    // Count strobe cycles and ready pulses mid-cycle.
    always @(negedge clk) begin
        if (!ram_cs_b)  cs_cnt++;
        if (!ram_oe_b)  oe_cnt++;
        if (!ram_wr_b)  wr_cnt++;
        if (ram_dq_oe)  dqoe_cnt++;
        if (a_ready)    a_rdy_cnt++;
        if (b_ready)    b_rdy_cnt++;
        if (ram_dq_oe && !ram_oe_b) bus_viol++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        cs_cnt = 0; oe_cnt = 0; wr_cnt = 0; dqoe_cnt = 0; a_rdy_cnt = 0; b_rdy_cnt = 0;
    endtask

    task automatic drop_all();
        a_rd = 0; a_wr = 0; b_rd = 0; b_wr = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drop_all();
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Single-port request; rd/wr held one cycle past ready, then dropped.
    task automatic run_req(input logic port, input logic rd, input logic wr,
                           input logic [18:0] addr, input logic [3:0] be,
                           input logic [31:0] wd, output int lat);
        logic got;
        if (port == 1'b0) begin
            a_rd = rd; a_wr = wr; a_addr = addr; a_be = be; a_wdata = wd;
        end else begin
            b_rd = rd; b_wr = wr; b_addr = addr; b_be = be; b_wdata = wd;
        end
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            lat++;
            got = (port == 1'b0) ? a_ready : b_ready;
        end
        check("ready_seen", {31'd0, got}, 32'd1);
        step();
        drop_all();
        step();
        step();
    endtask

    // Both ports read at once; records which ready came first and when.
    task automatic dual_read(input logic [18:0] aa, input logic [18:0] ba,
                             output int first, output int a_cyc, output int b_cyc);
        logic a_done, b_done;
        a_rd = 1; a_wr = 0; a_addr = aa; a_be = 4'hF;
        b_rd = 1; b_wr = 0; b_addr = ba; b_be = 4'hF;
        a_done = 0; b_done = 0; first = 2; a_cyc = 0; b_cyc = 0;
        for (int i = 1; i < 60 && (a_rd || b_rd); i++) begin
            step();
            if (a_done) a_rd = 0;
            if (b_done) b_rd = 0;
            if (a_ready && !a_done) begin a_done = 1; a_cyc = i; if (first == 2) first = 0; end
            if (b_ready && !b_done) begin b_done = 1; b_cyc = i; if (first == 2) first = 1; end
        end
        check("dual_done", {30'd0, a_done, b_done}, 32'd3);
        drop_all();
        step();
        step();
    endtask

    initial begin
        int lat, first, a_cyc, b_cyc;
        rst = 1'b1;
        drop_all();
        a_addr = 0; b_addr = 0; a_be = 0; b_be = 0; a_wdata = 0; b_wdata = 0;
        mem[19'h00010] = 32'hDEADBEEF;
        mem[19'h00100] = 32'hAABBCCDD;
        mem[19'h00020] = 32'h01020304;
        mem[19'h00030] = 32'hCAFEF00D;
        clear_mon();
        do_reset();

        // Reset state
        check("rst_strobes", {27'd0, ram_cs_b, ram_oe_b, ram_wr_b, ram_ub_b, ram_lb_b}, 32'h1F);
        check("rst_dq_oe_ready", {29'd0, ram_dq_oe, a_ready, b_ready}, 32'd0);
        check("rst_addr", {13'd0, ram_addr}, 32'd0);
        check("rst_rdata", a_rdata | b_rdata | ram_dq_out, 32'd0);

        // Port A read of 0x00010
        clear_mon();
        run_req(1'b0, 1, 0, 19'h00010, 4'hF, 32'h0, lat);
        check("rd_latency", lat, 3);
        check("rd_rdata", a_rdata, 32'hDEADBEEF);
        check("rd_cs_cycles", cs_cnt, 2);
        check("rd_oe_cycles", oe_cnt, 2);
        check("rd_a_pulses", a_rdy_cnt, 1);
        check("rd_b_pulses", b_rdy_cnt, 0);

        // Full write to top of memory, then read it back
        clear_mon();
        run_req(1'b0, 0, 1, 19'h7FFFF, 4'hF, 32'h12345678, lat);
        check("wr_latency", lat, 3);
        check("wr_wr_cycles", wr_cnt, 2);
        check("wr_dqoe_cycles", dqoe_cnt, 2);
        check("wr_oe_cycles", oe_cnt, 0);
        check("wr_addr", {13'd0, ram_addr}, 32'h7FFFF);
        check("wr_a_pulses", a_rdy_cnt, 1);
        check("wr_mem", mem[19'h7FFFF], 32'h12345678);
        run_req(1'b0, 1, 0, 19'h7FFFF, 4'hF, 32'h0, lat);
        check("wr_readback", a_rdata, 32'h12345678);

        // Partial write from port B: read-modify-write
        clear_mon();
        run_req(1'b1, 0, 1, 19'h00100, 4'b0101, 32'h11223344, lat);
        check("rmw_latency", lat, 5);
        check("rmw_cs_cycles", cs_cnt, 4);
        check("rmw_oe_cycles", oe_cnt, 2);
        check("rmw_wr_cycles", wr_cnt, 2);
        check("rmw_mem", mem[19'h00100], 32'hAA22CC44);
        check("rmw_b_pulses", b_rdy_cnt, 1);
        check("rmw_a_pulses", a_rdy_cnt, 0);
        check("rmw_a_rdata_hold", a_rdata, 32'h12345678);

        // Write with no byte enables: no SRAM access
        clear_mon();
        run_req(1'b0, 0, 1, 19'h00010, 4'b0000, 32'h55555555, lat);
        check("be0_latency", lat, 1);
        check("be0_strobes", cs_cnt + oe_cnt + wr_cnt + dqoe_cnt, 0);
        check("be0_a_pulses", a_rdy_cnt, 1);
        check("be0_mem", mem[19'h00010], 32'hDEADBEEF);

        // Reset while a full write is in progress
        clear_mon();
        a_rd = 0; a_wr = 1; a_addr = 19'h00040; a_be = 4'hF; a_wdata = 32'h00000055;
        step();                       // grant edge: WRITE, lcount = 1
        check("rstmid_in_write", {30'd0, ram_wr_b, ram_dq_oe}, 32'd1);
        rst = 1'b1;
        step();
        check("rstmid_strobes", {27'd0, ram_cs_b, ram_oe_b, ram_wr_b, ram_ub_b, ram_lb_b}, 32'h1F);
        check("rstmid_dq_oe", {31'd0, ram_dq_oe}, 32'd0);
        rst = 1'b0;
        drop_all();
        step();
        step();
        check("rstmid_no_ready", a_rdy_cnt + b_rdy_cnt, 0);
        clear_mon();
        run_req(1'b0, 0, 1, 19'h00040, 4'hF, 32'h0BADF00D, lat);
        check("rstmid_reissue_lat", lat, 3);
        check("rstmid_reissue_pulses", a_rdy_cnt, 1);
        run_req(1'b1, 1, 0, 19'h00040, 4'hF, 32'h0, lat);
        check("rstmid_readback", b_rdata, 32'h0BADF00D);

        // Simultaneous requests after reset: A first, B immediately after
        do_reset();
        clear_mon();
        dual_read(19'h00020, 19'h00030, first, a_cyc, b_cyc);
        check("tie1_first", first, 0);
        check("tie1_a_cycle", a_cyc, 3);
        check("tie1_b_cycle", b_cyc, 6);
        check("tie1_a_rdata", a_rdata, 32'h01020304);
        check("tie1_b_rdata", b_rdata, 32'hCAFEF00D);
        check("tie1_pulses", {a_rdy_cnt[15:0], b_rdy_cnt[15:0]}, {16'd1, 16'd1});

        // A alone leaves last_grant = A, so the next tie goes to B
        run_req(1'b0, 1, 0, 19'h00010, 4'hF, 32'h0, lat);
        dual_read(19'h00030, 19'h00020, first, a_cyc, b_cyc);
        check("tie2_first", first, 1);
        check("tie2_b_cycle", b_cyc, 3);
        check("tie2_a_cycle", a_cyc, 6);
        check("tie2_a_rdata", a_rdata, 32'hCAFEF00D);
        check("tie2_b_rdata", b_rdata, 32'h01020304);

        check("bus_contention", bus_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
